// File: rtl/soc_hashing.sv
// Byte-wide Ascon-Hash wrapper: message load, round-per-cycle hash engine, digest readout.
// Optional SOC_HASH_READ_WRAP_EN: digest read index wraps instead of saturating.
module soc_hashing #(
    parameter int R = 64,
    parameter int A = 12,
    parameter int B = 12,
    parameter int H = 256,
    parameter int L = 256,
    parameter int Y = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reg_inputxSS,
    input  logic [7:0] messagexSI,
    input  logic       reg_startxSS,
    input  logic       hash_startxSI,
    output logic       hash_readyxSO,
    input  logic       reg_outxSS,
    output logic [7:0] hash_digestxSO
);

    localparam int NB = Y / R + 1;
    localparam int P  = NB * R;
    localparam int NW = L / R;
    localparam int NI = Y / 8;
    localparam int NJ = L / 8;
    localparam int IW = $clog2(NI + 1);
    localparam int JW = $clog2(NJ + 1);
    localparam int BW = $clog2(NB + 1);
    localparam int WW = $clog2(NW + 1);
    localparam logic [63:0] IV = {8'h00, 8'(R), 8'(A), 8'(A - B), 32'(H)};

    typedef enum logic [2:0] {
        IDLE, INIT, ABSORB, ABS_PERM, SQUEEZE, SQZ_PERM, FIN, DONE
    } fsm_t;

    fsm_t           fsm;
    logic [Y-1:0]   message;
    logic [IW-1:0]  i;
    logic [JW-1:0]  j;
    logic [BW-1:0]  blk;
    logic [WW-1:0]  wrd;
    logic [3:0]     ri;
    logic [319:0]   s;
    logic [L-1:0]   digest;
    logic [P-1:0]   padded;
    logic [P-1:0]   psh;
    logic [L-1:0]   dsh;

    function automatic logic [319:0] ascon_round(input logic [319:0] st, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = st;
        x2 = x2 ^ {56'h0, ~r, r};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
        x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
        x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
        x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
        x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
        return {x0, x1, x2, x3, x4};
    endfunction

    assign padded = P'({message, 8'h80}) << (P - Y - 8);
    assign psh    = padded << (R * blk);
    assign dsh    = digest << {j, 3'b000};
    // Gated by ready so a recomputation in progress never leaks partial digest bytes.
    assign hash_digestxSO = hash_readyxSO ? dsh[L-1 -: 8] : 8'h00;

    // Every p^n run ends on round index 11, so one counter serves all permutation lengths.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm           <= IDLE;
            message       <= '0;
            i             <= '0;
            j             <= '0;
            blk           <= '0;
            wrd           <= '0;
            ri            <= '0;
            s             <= '0;
            digest        <= '0;
            hash_readyxSO <= 1'b0;
        end else begin
            if (reg_inputxSS && (fsm == IDLE || fsm == DONE) && i < IW'(NI)) begin
                message[Y-1-8*i -: 8] <= messagexSI;
                i <= i + 1'b1;
            end
            if (reg_outxSS && hash_readyxSO) begin
`ifdef SOC_HASH_READ_WRAP_EN
                j <= (j == JW'(NJ - 1)) ? '0 : j + 1'b1;
`else
                if (j < JW'(NJ)) j <= j + 1'b1;
`endif
            end
            case (fsm)
                IDLE, DONE: begin
                    if (reg_startxSS && hash_startxSI) begin
                        fsm           <= INIT;
                        s             <= {IV, 256'h0};
                        ri            <= 4'(12 - A);
                        blk           <= '0;
                        wrd           <= '0;
                        j             <= '0;
                        hash_readyxSO <= 1'b0;
                    end
                end
                INIT: begin
                    s <= ascon_round(s, ri);
                    if (ri == 4'd11) fsm <= ABSORB;
                    else ri <= ri + 1'b1;
                end
                ABSORB: begin
                    s[319:256] <= s[319:256] ^ psh[P-1 -: R];
                    ri  <= (blk == BW'(NB - 1)) ? 4'(12 - A) : 4'(12 - B);
                    blk <= blk + 1'b1;
                    fsm <= ABS_PERM;
                end
                ABS_PERM: begin
                    s <= ascon_round(s, ri);
                    if (ri == 4'd11) fsm <= (blk == BW'(NB)) ? SQUEEZE : ABSORB;
                    else ri <= ri + 1'b1;
                end
                SQUEEZE: begin
                    digest <= (digest << R) | L'(s[319:256]);
                    wrd    <= wrd + 1'b1;
                    if (wrd == WW'(NW - 1)) begin
                        fsm <= FIN;
                    end else begin
                        fsm <= SQZ_PERM;
                        ri  <= 4'(12 - B);
                    end
                end
                SQZ_PERM: begin
                    s <= ascon_round(s, ri);
                    if (ri == 4'd11) fsm <= SQUEEZE;
                    else ri <= ri + 1'b1;
                end
                FIN: begin
                    hash_readyxSO <= 1'b1;
                    fsm           <= DONE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_hashing.sv
// Directed bench for soc_hashing: table-driven Ascon reference model feeds a digest-byte scoreboard.
module tb_soc_hashing;

    localparam int LAT = 12 + (40 / 64) * 13 + 13 + 3 * 12 + 4 + 1;
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reg_inputxSS = 1'b0;
    logic [7:0] messagexSI = 8'h00;
    logic       reg_startxSS = 1'b0;
    logic       hash_startxSI = 1'b0;
    logic       hash_readyxSO;
    logic       reg_outxSS = 1'b0;
    logic [7:0] hash_digestxSO;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];
    logic [255:0] kat;
    logic [255:0] dref;
    logic [39:0]  m1;

    soc_hashing dut (
        .clk            (clk),
        .rst            (rst),
        .reg_inputxSS   (reg_inputxSS),
        .messagexSI     (messagexSI),
        .reg_startxSS   (reg_startxSS),
        .hash_startxSI  (hash_startxSI),
        .hash_readyxSO  (hash_readyxSO),
        .reg_outxSS     (reg_outxSS),
        .hash_digestxSO (hash_digestxSO)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] st, input int n);
        logic [63:0] w [5];
        logic [4:0] o;
        for (int k = 0; k < 5; k++) w[k] = st[319 - 64 * k -: 64];
        for (int r = 12 - n; r < 12; r++) begin
            w[2] = w[2] ^ 64'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                o = SBOX[{w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]}];
                w[0][b] = o[4]; w[1][b] = o[3]; w[2][b] = o[2]; w[3][b] = o[1]; w[4][b] = o[0];
            end
            w[0] = w[0] ^ ror(w[0], 19) ^ ror(w[0], 28);
            w[1] = w[1] ^ ror(w[1], 61) ^ ror(w[1], 39);
            w[2] = w[2] ^ ror(w[2], 1)  ^ ror(w[2], 6);
            w[3] = w[3] ^ ror(w[3], 10) ^ ror(w[3], 17);
            w[4] = w[4] ^ ror(w[4], 7)  ^ ror(w[4], 41);
        end
        return {w[0], w[1], w[2], w[3], w[4]};
    endfunction

    function automatic logic [255:0] ref_hash(input logic [39:0] msg);
        logic [319:0] st;
        logic [255:0] d;
        d  = '0;
        st = {64'h00400c0000000100, 256'h0};
        st = ref_perm(st, 12);
        st[319:256] = st[319:256] ^ {msg, 8'h80, 16'h0000};
        st = ref_perm(st, 12);
        for (int w = 0; w < 4; w++) begin
            d = {d[191:0], st[319:256]};
            if (w < 3) st = ref_perm(st, 12);
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        reg_inputxSS = 1'b1;
        messagexSI   = b;
        tick();
        reg_inputxSS = 1'b0;
    endtask

    task automatic load_msg(input logic [39:0] msg);
        logic [39:0] m;
        m = msg;
        for (int k = 0; k < 5; k++) write_byte(m[39 - 8 * k -: 8]);
    endtask

    task automatic push_digest(input logic [255:0] d);
        for (int k = 0; k < 32; k++) exp_q.push_back(d[255 - 8 * k -: 8]);
    endtask

    // Start held for 'hold' edges, optional byte write on the first; latency counted from the first edge.
    task automatic launch(input int hold, input logic wr, input logic [7:0] b, input string tag);
        int n;
        reg_startxSS  = 1'b1;
        hash_startxSI = 1'b1;
        reg_inputxSS  = wr;
        messagexSI    = b;
        tick();
        reg_inputxSS = 1'b0;
        n = 0;
        chk({tag, "_ready_low"}, 32'(hash_readyxSO), 32'd0);
        for (int h = 1; h < hold; h++) begin
            tick();
            n++;
        end
        reg_startxSS  = 1'b0;
        hash_startxSI = 1'b0;
        while (!hash_readyxSO && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(LAT));
    endtask

    task automatic read_bytes(input int cnt, input string tag);
        logic [7:0] e;
        for (int k = 0; k < cnt; k++) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_queue_empty"}, 32'(hash_digestxSO), 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%s_byte%0d", tag, k), 32'(hash_digestxSO), 32'(e));
            end
            reg_outxSS = 1'b1;
            tick();
            reg_outxSS = 1'b0;
        end
    endtask

    initial begin
        kat = ref_hash(40'h0001020304);

        tick();
        tick();
        rst = 1'b0;
        chk("reset_ready", 32'(hash_readyxSO), 32'd0);
        chk("reset_digest", 32'(hash_digestxSO), 32'd0);

        // KAT with readout past the end
        load_msg(40'h0001020304);
        launch(1, 1'b0, 8'h00, "kat");
        push_digest(kat);
`ifdef SOC_HASH_READ_WRAP_EN
        exp_q.push_back(kat[255:248]);
        exp_q.push_back(kat[247:240]);
`else
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
`endif
        read_bytes(34, "kat");

        // Restart from DONE with start held 4 cycles
        launch(4, 1'b0, 8'h00, "restart");
        push_digest(kat);
        read_bytes(32, "restart");

        // Over-length write: extra bytes ignored
        do_reset();
        load_msg(40'h0001020304);
        write_byte(8'haa);
        write_byte(8'hbb);
        write_byte(8'hcc);
        launch(1, 1'b0, 8'h00, "overflow");
        push_digest(kat);
        read_bytes(32, "overflow");

        // Read strobes before ready have no effect
        do_reset();
        m1 = {$urandom(), 8'($urandom())};
        dref = ref_hash(m1);
        load_msg(m1);
        for (int k = 0; k < 3; k++) begin
            reg_outxSS = 1'b1;
            tick();
            reg_outxSS = 1'b0;
            chk("early_strobe_out", 32'(hash_digestxSO), 32'd0);
        end
        launch(1, 1'b0, 8'h00, "early");
        push_digest(dref);
        read_bytes(32, "early");

        // Reset in the middle of absorption aborts the run
        do_reset();
        load_msg(40'h0001020304);
        reg_startxSS  = 1'b1;
        hash_startxSI = 1'b1;
        tick();
        reg_startxSS  = 1'b0;
        hash_startxSI = 1'b0;
        repeat (12) tick();
        do_reset();
        chk("abort_ready", 32'(hash_readyxSO), 32'd0);
        chk("abort_digest", 32'(hash_digestxSO), 32'd0);
        repeat (80) tick();
        chk("abort_stays_idle", 32'(hash_readyxSO), 32'd0);
        load_msg(40'h0001020304);
        launch(1, 1'b0, 8'h00, "reload");
        push_digest(kat);
        read_bytes(32, "reload");

        // Last byte written in the same cycle as start
        do_reset();
        for (int k = 0; k < 4; k++) write_byte(8'(k));
        launch(1, 1'b1, 8'h04, "wr_start");
        push_digest(kat);
        read_bytes(32, "wr_start");

        // Partial message: unwritten bytes stay zero
        do_reset();
        write_byte(8'hde);
        write_byte(8'had);
        dref = ref_hash(40'hdead000000);
        launch(1, 1'b0, 8'h00, "partial");
        push_digest(dref);
        read_bytes(32, "partial");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
